assoc_cache_control: RTL

ASSOC_CACHE_CONTROL -- requirements
Module: assoc_cache_control

---
 rtl/assoc_cache_control.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/assoc_cache_control.sv
// assoc_cache_control: N-way set-associative cache controller with tree-PLRU replacement,
// dirty write-back, and memory retry backoff.
module assoc_cache_control #(
    parameter int WAYS = 4,
    parameter int RETRY_GAP = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cpu_action_stb,
    input  logic            cpu_action_cyc,
    input  logic            cpu_write,
    output logic            cpu_resp,
    output logic            cpu_retry,
    input  logic [WAYS-1:0] hit_way,
    input  logic [WAYS-1:0] valid_out,
    input  logic [WAYS-1:0] dirty_out,
    input  logic [WAYS-2:0] lru_out,
    output logic [WAYS-1:0] valid_write,
    output logic [WAYS-1:0] tag_write,
    output logic [WAYS-1:0] data_write,
    output logic [WAYS-1:0] dirty_write,
    output logic            valid_in,
    output logic            dirty_in,
    output logic            lru_write,
    output logic [WAYS-2:0] lru_in,
    output logic            pmem_addr_sig,
    output logic            data_sig,
    output logic            mem_action_stb,
    output logic            mem_action_cyc,
    output logic            mem_write,
    input  logic            mem_resp,
    input  logic            mem_retry
);
    localparam int LG = $clog2(WAYS);
    localparam int NB = LG + 1;
    typedef enum logic [2:0] {IDLE, WRITE_BACK, STALL, FILL, BACKOFF} state_t;
    state_t state, next_state, resume, next_resume;
    logic [3:0] cnt, next_cnt;
    logic [LG-1:0] victim, next_victim, hit_idx, free_idx, plru_idx, w;
    logic [2*WAYS-1:0] tree, upd;
    logic [NB-1:0] vn, un;
    logic [WAYS-1:0] hit_oh, vic_oh;
    logic req, hit;
    assign req = cpu_action_stb & cpu_action_cyc;
    assign hit = |hit_way;
    assign hit_oh = WAYS'(1) << hit_idx;
    assign vic_oh = WAYS'(1) << victim;
    always_comb begin
        hit_idx = '0;
        free_idx = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (hit_way[i]) hit_idx = LG'(i);
            if (!valid_out[i]) free_idx = LG'(i);
        end
    end
    // Tree walk on a power-of-two padded copy so node indices never run past the vector.
    always_comb begin
        tree = {{(WAYS + 1){1'b0}}, lru_out};
        upd = tree;
        vn = '0;
        un = '0;
        w = hit_idx;
        for (int l = 0; l < LG; l++) begin
            vn = {vn[NB-2:0], 1'b0} + NB'(1) + NB'(tree[vn]);
            upd[un] = ~w[LG-1];
            un = {un[NB-2:0], 1'b0} + NB'(1) + NB'(w[LG-1]);
            w = w << 1;
        end
        plru_idx = LG'(vn - NB'(WAYS - 1));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            resume <= IDLE;
            victim <= '0;
            cnt <= '0;
        end else begin
            state <= next_state;
            resume <= next_resume;
            victim <= next_victim;
            cnt <= next_cnt;
        end
    end
    always_comb begin
        next_state = state;
        next_resume = resume;
        next_victim = victim;
        next_cnt = cnt;
        cpu_resp = 1'b0;
        valid_write = '0;
        tag_write = '0;
        data_write = '0;
        dirty_write = '0;
        valid_in = 1'b0;
        dirty_in = 1'b0;
        lru_write = 1'b0;
        lru_in = '0;
        pmem_addr_sig = 1'b0;
        data_sig = 1'b0;
        mem_action_stb = 1'b0;
        mem_action_cyc = 1'b0;
        mem_write = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (req && hit) begin
                        cpu_resp = 1'b1;
                        lru_write = 1'b1;
                        lru_in = upd[WAYS-2:0];
                        data_write = cpu_write ? hit_oh : '0;
                        dirty_write = cpu_write ? hit_oh : '0;
                        dirty_in = cpu_write;
                    end else if (req) begin
                        next_victim = (&valid_out) ? plru_idx : free_idx;
                        next_state = (valid_out[next_victim] && dirty_out[next_victim]) ? WRITE_BACK : FILL;
                    end
                end
                WRITE_BACK: begin
                    mem_action_stb = 1'b1;
                    mem_action_cyc = 1'b1;
                    mem_write = 1'b1;
                    pmem_addr_sig = 1'b1;
                    if (mem_resp) next_state = STALL;
                    else if (mem_retry) begin
                        next_state = BACKOFF;
                        next_resume = WRITE_BACK;
                        next_cnt = 4'(RETRY_GAP - 1);
                    end
                end
                STALL: next_state = FILL;
                FILL: begin
                    mem_action_stb = 1'b1;
                    mem_action_cyc = 1'b1;
                    data_sig = 1'b1;
                    valid_in = 1'b1;
                    if (mem_resp) begin
                        tag_write = vic_oh;
                        valid_write = vic_oh;
                        data_write = vic_oh;
                        dirty_write = vic_oh;
                        next_state = IDLE;
                    end else if (mem_retry) begin
                        next_state = BACKOFF;
                        next_resume = FILL;
                        next_cnt = 4'(RETRY_GAP - 1);
                    end
                end
                BACKOFF: begin
                    next_state = (cnt == 4'd0) ? resume : BACKOFF;
                    next_cnt = (cnt == 4'd0) ? cnt : cnt - 4'd1;
                end
                default: next_state = IDLE;
            endcase
        end
    end
    assign cpu_retry = req & ~cpu_resp & ~rst;
endmodule
